// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and scoreboard entry type for pipe_ctrl
package pipe_pkg;

    localparam int REGW_DEF = 5;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MDIV   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    typedef struct packed {
        logic                load;
        logic                wen;
        logic [REGW_DEF-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - shifting destination tracker with load-use compare
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                issue_en,
    input  sb_entry_t           id_entry,
    input  logic                id_valid,
    input  logic [REGW_DEF-1:0] id_rs1,
    input  logic [REGW_DEF-1:0] id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    output logic                load_use
);

    sb_entry_t sb_q [DEPTH];
    sb_entry_t sb_d [DEPTH];

    // Shifts every cycle in lockstep with the stage pipeline; bubbles enter as zero entries.
    always_comb begin
        sb_d[0] = issue_en ? id_entry : '0;
        for (int i = 1; i < DEPTH; i++) begin
            sb_d[i] = sb_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    logic ex_pending;
    logic hit_rs1;
    logic hit_rs2;

    // Only a load in EX can stall; MEM/WB results are forwarded.
    always_comb begin
        ex_pending = sb_q[0].load & sb_q[0].wen & (sb_q[0].rd != '0);
        hit_rs1    = id_use_rs1 & (id_rs1 == sb_q[0].rd);
        hit_rs2    = id_use_rs2 & (id_rs2 == sb_q[0].rd);
        load_use   = id_valid & ex_pending & (hit_rs1 | hit_rs2);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - issue/stall/flush sequencing, mul/div occupancy and halt drain
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int REGW     = REGW_DEF,
    parameter int DEPTH    = 3,
    parameter int MDIV_LAT = 8,
    parameter int CNTW     = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_wen,
    input  logic            id_load,
    input  logic            id_mdiv,
    input  logic            id_halt,
    input  logic            ex_redirect,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            ifid_flush,
    output logic            issue_en,
    output logic            halted,
    output logic [CNTW-1:0] bubble_cnt,
    output logic [1:0]      state
);

    localparam int CW = $clog2(MDIV_LAT + DEPTH + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CNTW-1:0] bubble_q, bubble_d;
    logic            load_use;
    sb_entry_t       id_entry;

    logic pc_en_c, ifid_en_c, ifid_flush_c, issue_en_c;

    assign id_entry = '{load: id_load, wen: id_wen, rd: id_rd};

    pipe_scoreboard #(.DEPTH(DEPTH)) u_sb (
        .clk        (clk),
        .rstn       (rstn),
        .issue_en   (issue_en),
        .id_entry   (id_entry),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .load_use   (load_use)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        ifid_flush_c = 1'b0;
        issue_en_c   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (ex_redirect) begin
                    pc_en_c      = 1'b1;
                    ifid_en_c    = 1'b1;
                    ifid_flush_c = 1'b1;
                end else if (!load_use) begin
                    pc_en_c    = 1'b1;
                    ifid_en_c  = 1'b1;
                    issue_en_c = id_valid;
                end
                // Halt wins over mul/div when an instruction carries both.
                if (issue_en_c && id_halt) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CW'(DEPTH);
                end else if (issue_en_c && id_mdiv) begin
                    state_d = ST_MDIV;
                    cnt_d   = CW'(MDIV_LAT - 1);
                end
            end
            ST_MDIV: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = ST_RUN;
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = ST_HALTED;
            end
            default: ;
        endcase
    end

    // Bubble accounting covers RUN and MDIV only; drain and halt cycles are not stalls.
    always_comb begin
        bubble_d = bubble_q;
        if ((state_q == ST_RUN || state_q == ST_MDIV) && !issue_en_c && (bubble_q != '1)) begin
            bubble_d = bubble_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bubble_q <= bubble_d;
        end
    end

    // Enables are forced low for the whole time reset is held, not just after the next edge.
    assign pc_en      = rstn & pc_en_c;
    assign ifid_en    = rstn & ifid_en_c;
    assign ifid_flush = rstn & ifid_flush_c;
    assign issue_en   = rstn & issue_en_c;
    assign halted     = (state_q == ST_HALTED);
    assign bubble_cnt = bubble_q;
    assign state      = state_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32 core. It decides each cycle whether the decode-stage instruction is issued into the stage shift pipeline or a bubble (the init/NOP value) is injected instead, and whether PC and the IF/ID register advance or hold. It handles load-use hazards, branch redirect flushes, multi-cycle mul/div occupancy and a halt/drain sequence, and keeps a bubble performance counter.

Parameters:
REGW, 5, register index width
DEPTH, 3, scoreboard stages tracked after ID (EX, MEM, WB)
MDIV_LAT, 8, EX occupancy in cycles of a mul/div instruction (>=2)
CNTW, 32, bubble counter width

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
id_valid  in  1  ID holds a valid instruction
id_rs1  in  REGW  source 1 index
id_rs2  in  REGW  source 2 index
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  REGW  destination index
id_wen  in  1  instruction writes rd
id_load  in  1  instruction is a load
id_mdiv  in  1  instruction is mul/div
id_halt  in  1  instruction is ebreak (halt request)
ex_redirect  in  1  taken branch/jump resolved in EX this cycle
pc_en  out  1  PC register loads (next PC or redirect target)
ifid_en  out  1  IF/ID register loads
ifid_flush  out  1  IF/ID register loads NOP
issue_en  out  1  1: issue ID instruction into pipeline; 0: inject bubble
halted  out  1  core fully drained after halt
bubble_cnt  out  CNTW  number of cycles with issue_en=0 while in RUN/MDIV
state  out  2  FSM state, for debug

Behaviour:
- Reset (async, rstn low): state=RUN, scoreboard cleared, counters 0, halted=0, bubble_cnt=0. While rstn is low, pc_en, ifid_en, ifid_flush and issue_en are all 0.
- Scoreboard: DEPTH entries {load, wen, rd}. The scoreboard shifts every cycle, matching the unconditionally shifting stage pipeline. Entry 0 (EX) loads ID info when issue_en=1, zeros otherwise. Entries with rd=0 never cause hazards.
- Load-use hazard (combinational): id_valid & sb[0].load & sb[0].wen & sb[0].rd!=0 & ((id_use_rs1 & id_rs1==sb[0].rd) | (id_use_rs2 & id_rs2==sb[0].rd)). Results from MEM/WB are forwarded; no other stalls exist.
- Output priority in RUN (highest first):
  1. ex_redirect: pc_en=1, ifid_flush=1, ifid_en=1, issue_en=0. Overrides any hazard.
  2. load-use: pc_en=0, ifid_en=0, issue_en=0 for exactly one cycle. No state change.
  3. Otherwise: pc_en=1, ifid_en=1, issue_en=id_valid.
- FSM states: RUN=0, MDIV=1, DRAIN=2, HALTED=3.
  - RUN->MDIV: when issue_en=1 & id_mdiv. Load cnt=MDIV_LAT-1.
  - MDIV: pc_en=ifid_en=issue_en=0. cnt decrements each cycle; at cnt==1 go to RUN, so the next ID instruction issues exactly MDIV_LAT cycles after the mul/div issued. ex_redirect cannot occur in MDIV and is ignored.
  - RUN->DRAIN: when issue_en=1 & id_halt. Load cnt=DEPTH. pc_en=ifid_en=issue_en=0 from the next cycle on.
  - DRAIN: cnt decrements each cycle; at cnt==1 go to HALTED.
  - HALTED: absorbing until reset. halted=1, all enables 0.
  - id_halt and id_mdiv both set: halt takes precedence (enter DRAIN).
- bubble_cnt increments every cycle with issue_en=0 while state is RUN or MDIV, whatever the cause, including cycles with id_valid=0. It saturates at all-ones.

Decomposition:
Shared package pipe_pkg holds the state encoding constants (RUN/MDIV/DRAIN/HALTED), the scoreboard entry typedef {load, wen, rd}, and the REGW default. One natural sub-module: pipe_scoreboard, the DEPTH-entry shifting hazard tracker with a load-use compare output. The FSM, counters and output decode stay in pipe_ctrl.

Test Plan:
1. lw x5 issued, next ID add x6,x5,x1 -> one cycle with pc_en=0, ifid_en=0, issue_en=0; add issues the following cycle; bubble_cnt=1.
2. lw x0 followed by a user of x0, and lw x5 followed by an instruction not reading x5 -> no stall, issue_en=1 every cycle.
3. Load-use hazard and ex_redirect in the same cycle -> ifid_flush=1, pc_en=1, issue_en=0; no hold the next cycle.
4. mul issued with MDIV_LAT=8 -> state=MDIV for 7 cycles with all enables 0; next instruction issues 8 cycles after the mul; bubble_cnt=7.
5. ebreak issued, DEPTH=3 -> DRAIN for 3 cycles, then halted=1 and state=HALTED permanently; further id_valid ignored.
6. rstn asserted mid-MDIV (cnt=4) -> immediately state=RUN, outputs 0 while low; after release, normal issue with bubble_cnt=0.
